// File: rtl/qdec_mv_recon_if.sv
// Handshake/bus bundle for qdec_mv_recon: MVD syntax-element input,
// AMVP predictor input, reconstructed-MV output and error pulses.
// slave = the reconstruction block, master = its environment.
interface qdec_mv_recon_if #(parameter int MV_W = 16);
   // MVD syntax elements from the CABAC MVD sub-FSM
   logic            mvd_in_vld;
   logic            mvd_in_rdy;
   logic [1:0]      mvd_gt0;
   logic [1:0]      mvd_gt1;
   logic [15:0]     mvd_minus2_x;
   logic [15:0]     mvd_minus2_y;
   logic [1:0]      mvd_sign;
   logic            mvd_list;
   // AMVP predictor
   logic            mvp_in_vld;
   logic            mvp_in_rdy;
   logic [MV_W-1:0] mvp_x;
   logic [MV_W-1:0] mvp_y;
   logic            mvp_list;
   // reconstructed MV towards MV storage / MC request
   logic            mv_vld;
   logic            mv_rdy;
   logic [MV_W-1:0] mv_x;
   logic [MV_W-1:0] mv_y;
   logic [MV_W-1:0] mvd_x;
   logic [MV_W-1:0] mvd_y;
   logic            mv_list;
   logic            err_list;
   logic            err_range;

   modport slave (
      input  mvd_in_vld, mvd_gt0, mvd_gt1, mvd_minus2_x, mvd_minus2_y, mvd_sign, mvd_list,
      output mvd_in_rdy,
      input  mvp_in_vld, mvp_x, mvp_y, mvp_list,
      output mvp_in_rdy,
      output mv_vld, mv_x, mv_y, mvd_x, mvd_y, mv_list, err_list, err_range,
      input  mv_rdy
   );

   modport master (
      output mvd_in_vld, mvd_gt0, mvd_gt1, mvd_minus2_x, mvd_minus2_y, mvd_sign, mvd_list,
      input  mvd_in_rdy,
      output mvp_in_vld, mvp_x, mvp_y, mvp_list,
      input  mvp_in_rdy,
      input  mv_vld, mv_x, mv_y, mvd_x, mvd_y, mv_list, err_list, err_range,
      output mv_rdy
   );
endinterface

// File: rtl/qdec_mv_recon.sv
// qdec_mv_recon: rebuilds the signed MVD from its syntax elements, adds the
// AMVP predictor of the same list (wrap-around) and queues the MV in a small
// in-order FIFO. Pipeline: holding regs -> compute stage -> FIFO.
// Optional: define QDEC_MVD_RANGE_CHK_EN to flag signed MVDs outside
// [-2^15, 2^15-1] on err_range (else err_range is tied 0).
module qdec_mv_recon #(
   parameter int MV_W       = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   qdec_mv_recon_if.slave  bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

   typedef struct packed {
      logic [MV_W-1:0] mv_x;
      logic [MV_W-1:0] mv_y;
      logic [MV_W-1:0] mvd_x;
      logic [MV_W-1:0] mvd_y;
      logic            list;
   } mv_entry_t;

   // |MVD| from the greater0/greater1/minus2 triple, then sign applied; 18-bit signed
   function automatic logic [17:0] smvd_f(input logic gt0, input logic gt1,
                                          input logic sgn, input logic [15:0] m2);
      logic [16:0] a;
      a = gt0 ? (gt1 ? ({1'b0, m2} + 17'd2) : 17'd1) : 17'd0;
      return sgn ? -{1'b0, a} : {1'b0, a};
   endfunction

   // holding registers
   logic            mvd_held, mvp_held;
   logic [1:0]      h_gt0, h_gt1, h_sign;
   logic [15:0]     h_m2x, h_m2y;
   logic            h_dlist;
   logic [MV_W-1:0] h_px, h_py;
   logic            h_plist;

   // compute stage / FIFO state
   logic            stage_vld;
   mv_entry_t       stage;
   mv_entry_t       mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [AW:0]     cnt, occ;
   logic            err_list_q;

   logic            join_fire, list_ok, push, pop, mv_vld_w;
   logic [17:0]     smvd_x, smvd_y;
   mv_entry_t       calc, head;

   // stage plus FIFO occupancy bounds joins, so a push can never overflow
   assign occ       = cnt + (AW+1)'(stage_vld);
   assign join_fire = mvd_held & mvp_held & (occ < DEPTH_C);
   assign list_ok   = (h_dlist == h_plist);
   assign push      = stage_vld;
   assign mv_vld_w  = (cnt != '0);
   assign pop       = mv_vld_w & bus.mv_rdy;

   assign bus.mvd_in_rdy = ~mvd_held | join_fire;
   assign bus.mvp_in_rdy = ~mvp_held | join_fire;

   // signed MVD and wrapped MV for the pair sitting in the holding regs
   always_comb begin
      smvd_x     = smvd_f(h_gt0[0], h_gt1[0], h_sign[0], h_m2x);
      smvd_y     = smvd_f(h_gt0[1], h_gt1[1], h_sign[1], h_m2y);
      calc       = '0;
      calc.mvd_x = MV_W'(smvd_x);
      calc.mvd_y = MV_W'(smvd_y);
      calc.mv_x  = h_px + calc.mvd_x;
      calc.mv_y  = h_py + calc.mvd_y;
      calc.list  = h_plist;
   end

   // MVD holding reg: refill may land on the join edge; flush wins over a handshake
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         mvd_held <= 1'b0;
      end else if (bus.mvd_in_vld && bus.mvd_in_rdy) begin
         mvd_held <= 1'b1;
         h_gt0    <= bus.mvd_gt0;
         h_gt1    <= bus.mvd_gt1;
         h_sign   <= bus.mvd_sign;
         h_m2x    <= bus.mvd_minus2_x;
         h_m2y    <= bus.mvd_minus2_y;
         h_dlist  <= bus.mvd_list;
      end else if (join_fire) begin
         mvd_held <= 1'b0;
      end
   end

   // MVP holding reg, same refill rule
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         mvp_held <= 1'b0;
      end else if (bus.mvp_in_vld && bus.mvp_in_rdy) begin
         mvp_held <= 1'b1;
         h_px     <= bus.mvp_x;
         h_py     <= bus.mvp_y;
         h_plist  <= bus.mvp_list;
      end else if (join_fire) begin
         mvp_held <= 1'b0;
      end
   end

   // compute stage: matched pairs load, mismatched pairs are dropped and flagged
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         stage_vld  <= 1'b0;
         err_list_q <= 1'b0;
      end else begin
         stage_vld  <= join_fire & list_ok;
         err_list_q <= join_fire & ~list_ok;
         if (join_fire) stage <= calc;
      end
   end

   // FIFO storage, no reset needed: reads are gated by cnt
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= stage;
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   cnt <= cnt + (AW+1)'(1);
            2'b01:   cnt <= cnt - (AW+1)'(1);
            default: ;
         endcase
      end
   end

   assign head         = mem[rd_ptr];
   assign bus.mv_vld   = mv_vld_w;
   assign bus.mv_x     = mv_vld_w ? head.mv_x  : '0;
   assign bus.mv_y     = mv_vld_w ? head.mv_y  : '0;
   assign bus.mvd_x    = mv_vld_w ? head.mvd_x : '0;
   assign bus.mvd_y    = mv_vld_w ? head.mvd_y : '0;
   assign bus.mv_list  = mv_vld_w ? head.list  : 1'b0;
   assign bus.err_list = err_list_q;

`ifdef QDEC_MVD_RANGE_CHK_EN
   logic stage_rng, err_range_q;

   // out of range when bits 17..15 of the 18-bit signed MVD disagree
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         stage_rng   <= 1'b0;
         err_range_q <= 1'b0;
      end else begin
         if (join_fire)
            stage_rng <= ((smvd_x[17:15] != 3'b000) && (smvd_x[17:15] != 3'b111)) ||
                         ((smvd_y[17:15] != 3'b000) && (smvd_y[17:15] != 3'b111));
         err_range_q <= stage_vld & stage_rng;
      end
   end
   assign bus.err_range = err_range_q;
`else
   assign bus.err_range = 1'b0;
`endif
endmodule

// File: tb/tb_qdec_mv_recon.sv
// Directed bench for qdec_mv_recon: reset state, arithmetic and wrap,
// range flag, back-pressure / ordering, list mismatch and flush.
module tb_qdec_mv_recon;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

`ifdef QDEC_MVD_RANGE_CHK_EN
   localparam logic RNG_EXP = 1'b1;
`else
   localparam logic RNG_EXP = 1'b0;
`endif

   qdec_mv_recon_if #(.MV_W(16)) bus ();
   qdec_mv_recon #(.MV_W(16), .FIFO_DEPTH(4)) dut (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus));

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // called at a negedge; returns at the negedge after the last acceptance edge
   task automatic send(input logic dm, input logic dp, input logic [1:0] g0, input logic [1:0] g1,
                       input logic [1:0] sg, input logic [15:0] m2x, input logic [15:0] m2y,
                       input logic dl, input logic [15:0] px, input logic [15:0] py, input logic pl);
      int   n;
      logic pd, pp, ad, ap;
      pd = dm; pp = dp; n = 0;
      if (dm) begin
         bus.mvd_in_vld = 1'b1; bus.mvd_gt0 = g0; bus.mvd_gt1 = g1; bus.mvd_sign = sg;
         bus.mvd_minus2_x = m2x; bus.mvd_minus2_y = m2y; bus.mvd_list = dl;
      end
      if (dp) begin
         bus.mvp_in_vld = 1'b1; bus.mvp_x = px; bus.mvp_y = py; bus.mvp_list = pl;
      end
      while ((pd || pp) && n < 40) begin
         ad = pd & bus.mvd_in_rdy;
         ap = pp & bus.mvp_in_rdy;
         @(negedge clk);
         if (ad) begin pd = 1'b0; bus.mvd_in_vld = 1'b0; end
         if (ap) begin pp = 1'b0; bus.mvp_in_vld = 1'b0; end
         n++;
      end
      if (pd || pp) begin
         vectors++;
         miscompares++;
         $error("FAIL send_timeout: observed pending=%0b%0b expected 00", pd, pp);
         bus.mvd_in_vld = 1'b0;
         bus.mvp_in_vld = 1'b0;
      end
   endtask

   // starts at negedge after edge E; output must appear after E+2
   task automatic expect_mv(input string tag, input logic [15:0] emx, input logic [15:0] emy,
                            input logic [15:0] edx, input logic [15:0] edy, input logic el,
                            input logic erng);
      chk({tag, "_vld_e0"}, bus.mv_vld, 0);
      @(negedge clk);
      chk({tag, "_vld_e1"}, bus.mv_vld, 0);
      @(negedge clk);
      chk({tag, "_vld_e2"}, bus.mv_vld, 1);
      chk({tag, "_mv_x"}, bus.mv_x, emx);
      chk({tag, "_mv_y"}, bus.mv_y, emy);
      chk({tag, "_mvd_x"}, bus.mvd_x, edx);
      chk({tag, "_mvd_y"}, bus.mvd_y, edy);
      chk({tag, "_list"}, bus.mv_list, el);
      chk({tag, "_err_range"}, bus.err_range, erng);
   endtask

   initial begin
      bus.mvd_in_vld = 0; bus.mvd_gt0 = 0; bus.mvd_gt1 = 0; bus.mvd_sign = 0;
      bus.mvd_minus2_x = 0; bus.mvd_minus2_y = 0; bus.mvd_list = 0;
      bus.mvp_in_vld = 0; bus.mvp_x = 0; bus.mvp_y = 0; bus.mvp_list = 0;
      bus.mv_rdy = 1;

      // reset state
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_mv_vld", bus.mv_vld, 0);
      chk("rst_mvd_rdy", bus.mvd_in_rdy, 1);
      chk("rst_mvp_rdy", bus.mvp_in_rdy, 1);
      chk("rst_mv_x", bus.mv_x, 0);
      chk("rst_err_list", bus.err_list, 0);
      chk("rst_err_range", bus.err_range, 0);

      // 1: mvd=(-5,1), mvp=(10,-2) -> mv=(5,-1); minus2_y ignored since gt1[1]=0
      send(1, 1, 2'b11, 2'b01, 2'b01, 16'd3, 16'h1234, 0, 16'd10, 16'hFFFE, 0);
      expect_mv("t1", 16'h0005, 16'hFFFF, 16'hFFFB, 16'h0001, 0, 0);
      @(negedge clk);
      chk("t1_popped", bus.mv_vld, 0);

      // 2: 32767 + 1 wraps to -32768, not a range error
      send(1, 1, 2'b01, 2'b00, 2'b00, 16'd0, 16'd0, 0, 16'h7FFF, 16'h0000, 0);
      expect_mv("t2", 16'h8000, 16'h0000, 16'h0001, 16'h0000, 0, 0);

      // 3: |mvd| = 32769 positive -> wrapped to -32767, range flag when enabled
      send(1, 1, 2'b01, 2'b01, 2'b00, 16'h7FFF, 16'd0, 0, 16'h0000, 16'h0000, 0);
      expect_mv("t3", 16'h8001, 16'h0000, 16'h8001, 16'h0000, 0, RNG_EXP);
      @(negedge clk);
      chk("t3_rng_pulse_end", bus.err_range, 0);
      // -32768 is the in-range edge
      send(1, 1, 2'b01, 2'b01, 2'b01, 16'h7FFE, 16'd0, 0, 16'h0000, 16'h0000, 0);
      expect_mv("t3b", 16'h8000, 16'h0000, 16'h8000, 16'h0000, 0, 0);
      // -32769 wraps to +32767, out of range
      send(1, 1, 2'b01, 2'b01, 2'b01, 16'h7FFF, 16'd0, 0, 16'h0001, 16'h0000, 0);
      expect_mv("t3c", 16'h8000, 16'h0000, 16'h7FFF, 16'h0000, 0, RNG_EXP);
      @(negedge clk);

      // 4: back-pressure; gt0=0 makes gt1/minus2 irrelevant, mv = mvp
      bus.mv_rdy = 0;
      for (int i = 1; i <= 5; i++)
         send(1, 1, 2'b00, 2'b11, 2'b11, 16'hAAAA, 16'h5555, 0, 16'(100 + i), 16'(i), 0);
      repeat (4) @(negedge clk);
      bus.mvd_in_vld = 1; bus.mvp_in_vld = 1; bus.mvp_x = 16'd106; bus.mvp_y = 16'd6;
      chk("t4_full_mvd_rdy", bus.mvd_in_rdy, 0);
      chk("t4_full_mvp_rdy", bus.mvp_in_rdy, 0);
      chk("t4_full_vld", bus.mv_vld, 1);
      chk("t4_head", bus.mv_x, 16'd101);
      @(negedge clk);
      chk("t4_still_mvd_rdy", bus.mvd_in_rdy, 0);
      chk("t4_still_mvp_rdy", bus.mvp_in_rdy, 0);
      bus.mv_rdy = 1;
      fork
         send(1, 1, 2'b00, 2'b11, 2'b11, 16'hAAAA, 16'h5555, 0, 16'd106, 16'd6, 0);
         begin
            for (int k = 1; k <= 6; k++) begin
               chk($sformatf("t4_out%0d_vld", k), bus.mv_vld, 1);
               chk($sformatf("t4_out%0d_x", k), bus.mv_x, 32'(100 + k));
               chk($sformatf("t4_out%0d_y", k), bus.mv_y, 32'(k));
               @(negedge clk);
            end
            chk("t4_drained", bus.mv_vld, 0);
         end
      join

      // 5: list mismatch -> err_list pulse, nothing queued
      send(1, 1, 2'b01, 2'b00, 2'b00, 16'd0, 16'd0, 1, 16'd50, 16'd50, 0);
      chk("t5_err_e0", bus.err_list, 0);
      @(negedge clk);
      chk("t5_err_e1", bus.err_list, 1);
      @(negedge clk);
      chk("t5_err_e2", bus.err_list, 0);
      chk("t5_no_write", bus.mv_vld, 0);
      send(1, 1, 2'b01, 2'b00, 2'b00, 16'd0, 16'd0, 1, 16'd7, 16'd8, 1);
      expect_mv("t5b", 16'd8, 16'd8, 16'd1, 16'd0, 1, 0);
      @(negedge clk);

      // 6: flush with 3 queued, MVD held, MVP handshake in the same cycle
      bus.mv_rdy = 0;
      for (int i = 1; i <= 3; i++)
         send(1, 1, 2'b00, 2'b00, 2'b00, 16'd0, 16'd0, 0, 16'(200 + i), 16'd0, 0);
      repeat (3) @(negedge clk);
      chk("t6_queued", bus.mv_vld, 1);
      send(1, 0, 2'b01, 2'b00, 2'b00, 16'd0, 16'd0, 0, 16'd0, 16'd0, 0);
      chk("t6_mvd_held", bus.mvd_in_rdy, 0);
      bus.mvp_in_vld = 1; bus.mvp_x = 16'd999; bus.mvp_y = 16'd999; bus.mvp_list = 0;
      flush = 1;
      chk("t6_mvp_hs", bus.mvp_in_rdy, 1);
      @(negedge clk);
      flush = 0;
      bus.mvp_in_vld = 0;
      chk("t6_flush_vld", bus.mv_vld, 0);
      chk("t6_flush_mvd_rdy", bus.mvd_in_rdy, 1);
      chk("t6_flush_mvp_rdy", bus.mvp_in_rdy, 1);
      chk("t6_flush_mv_x", bus.mv_x, 0);
      send(1, 0, 2'b01, 2'b00, 2'b00, 16'd0, 16'd0, 0, 16'd0, 16'd0, 0);
      repeat (3) @(negedge clk);
      chk("t6_mvp_discarded", bus.mv_vld, 0);
      chk("t6_mvd_waiting", bus.mvd_in_rdy, 0);
      send(0, 1, 2'b00, 2'b00, 2'b00, 16'd0, 16'd0, 0, 16'd20, 16'd30, 0);
      expect_mv("t6b", 16'd21, 16'd30, 16'd1, 16'd0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
